// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU data-memory responder.
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;
endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then holds
// the response until the CPU consumes it.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lat_write;
  logic [31:0]      lat_addr, lat_wdata;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             accept, commit;
  logic             acc_write, acc_err;
  logic [31:0]      acc_addr, acc_wdata, mem_rdata;

  assign accept = req_valid && (state == IDLE);

  // With zero wait states the commit edge is the acceptance edge, so the
  // access must come straight from the request port rather than the latches.
  assign acc_write = (state == IDLE) ? req_write : lat_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) state_nxt = RESP;
        else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: if (cnt == '0) state_nxt = RESP;
            else           cnt_nxt   = cnt - CNT_W'(1);
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign commit = (state_nxt == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_write) ? '0 : mem_rdata;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (commit && acc_write && !acc_err),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic against a word-array model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [31:0] z_resp_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [256];
  bit          written   [256];

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
  );

  function automatic bit addr_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 256);
  endfunction

  function automatic void model_commit(input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (wr && !addr_err(a)) begin
      model_mem[a / 4] = d;
      written[a / 4]   = 1'b1;
    end
  endfunction

  // Drive a request and return once the acceptance edge has passed.
  task automatic accept_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; resp_ready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Cycles from the acceptance edge until resp_valid is seen (1 = first sample after it).
  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic finish_req(input int hold, output logic [31:0] rd, output logic er, output bit stable);
    rd = resp_rdata; er = resp_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic er, output int lat, output bit stable);
    accept_req(wr, a, d);
    wait_resp(lat);
    finish_req(hold, rd, er, stable);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got v=%b e=%b d=%h expected 0/0/0", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_store;
    logic [31:0] rd; logic er; int lat; bit st;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, st);
    model_commit(1'b1, 32'h10, 32'hDEADBEEF);
    checks++; if (lat != 3) begin errors++; $display("FAIL store_latency: got %0d expected 3", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_resp: got e=%b d=%h expected 0/0", er, rd); end
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL store_idle: got v=%b d=%h rdy=%b expected 0/0/1", resp_valid, resp_rdata, req_ready);
    end
  endtask

  task automatic test_load_hold;
    logic [31:0] rd; logic er; int lat; bit st;
    do_req(1'b0, 32'h10, 32'h0, 4, rd, er, lat, st);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_data: got d=%h e=%b expected deadbeef/0", rd, er); end
    checks++; if (!st) begin errors++; $display("FAIL load_hold_stable: got unstable expected stable"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat; bit st;
    do_req(1'b1, 32'h3FC, 32'h55AA1234, 0, rd, er, lat, st);
    model_commit(1'b1, 32'h3FC, 32'h55AA1234);
    do_req(1'b0, 32'h12, 32'h0, 1, rd, er, lat, st);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned: got e=%b d=%h expected 1/0", er, rd); end
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 0, rd, er, lat, st);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL out_of_range: got e=%b d=%h expected 1/0", er, rd); end
    do_req(1'b0, 32'h3FC, 32'h0, 0, rd, er, lat, st);
    checks++; if (rd !== model_mem[255] || er !== 1'b0) begin
      errors++; $display("FAIL last_word_intact: got d=%h e=%b expected %h/0", rd, er, model_mem[255]);
    end
  endtask

  task automatic test_reset_wait;
    logic [31:0] rd; logic er; int lat; bit st;
    do_req(1'b1, 32'h20, 32'h0BADF00D, 0, rd, er, lat, st);
    model_commit(1'b1, 32'h20, 32'h0BADF00D);
    accept_req(1'b1, 32'h20, 32'h12345678);
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL reset_in_wait: got rdy=%b v=%b d=%h e=%b expected 1/0/0/0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 0, rd, er, lat, st);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL aborted_store: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_reset_resp;
    logic [31:0] rd; logic er; int lat; bit st;
    accept_req(1'b1, 32'h24, 32'hCAFEF00D);
    wait_resp(lat);
    model_commit(1'b1, 32'h24, 32'hCAFEF00D);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_before_reset: got %b expected 1", resp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_resp: got v=%b rdy=%b expected 0/1", resp_valid, req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b0, 32'h24, 32'h0, 0, rd, er, lat, st);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL committed_store: got %h expected cafef00d", rd); end
  endtask

  // Zero-wait instance: four stores then four loads with req_valid and resp_ready held high.
  task automatic test_back_to_back;
    logic [31:0] d [4];
    int k;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    @(negedge clk);
    z_resp_ready = 1'b1; z_req_valid = 1'b1;
    z_req_write = 1'b1; z_req_addr = 32'h0; z_req_wdata = d[0];
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        k = (i - 1) / 2;
        checks++; if (z_resp_valid !== 1'b1 || z_req_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_resp_cycle%0d: got v=%b rdy=%b expected 1/0", i, z_resp_valid, z_req_ready);
        end
        checks++; if (z_resp_rdata !== ((k < 4) ? 32'h0 : d[k-4]) || z_resp_err !== 1'b0) begin
          errors++; $display("FAIL b2b_data_op%0d: got %h expected %h", k, z_resp_rdata, (k < 4) ? 32'h0 : d[k-4]);
        end
        k++;
        if (k < 8) begin
          z_req_write = (k < 4); z_req_addr = 32'(4 * (k % 4)); z_req_wdata = (k < 4) ? d[k] : 32'h0;
        end else z_req_valid = 1'b0;
      end else begin
        checks++; if (z_resp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_idle_cycle%0d: got v=%b rdy=%b expected 0/1", i, z_resp_valid, z_req_ready);
        end
      end
    end
    z_resp_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d; logic er; int lat, kind, hold; bit st, wr;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      a = 32'(4 * $urandom_range(0, 15));
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'(4 * (256 + $urandom_range(0, 5000)));
      wr = $urandom_range(0, 1);
      d = $urandom;
      hold = $urandom_range(0, 3);
      do_req(wr, a, d, hold, rd, er, lat, st);
      checks++; if (er !== addr_err(a)) begin errors++; $display("FAIL rand_err a=%h: got %b expected %b", a, er, addr_err(a)); end
      checks++; if (lat != 3 || !st) begin errors++; $display("FAIL rand_timing a=%h: got lat=%0d stable=%0d expected 3/1", a, lat, st); end
      if (wr || addr_err(a)) begin
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rand_zero a=%h: got %h expected 0", a, rd); end
      end else if (written[a / 4]) begin
        checks++; if (rd !== model_mem[a / 4]) begin errors++; $display("FAIL rand_load a=%h: got %h expected %h", a, rd, model_mem[a / 4]); end
      end
      model_commit(wr, a, d);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_store;
    test_load_hold;
    test_errors;
    test_reset_wait;
    test_reset_resp;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, 4 to 4096.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response; 0 to 15.
REQ-003 One clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  the CPU memory stage presents a request.
REQ-007 req_ready  output  1  the responder accepts a request this cycle.
REQ-008 req_write  input  1  1 = store word, 0 = load word.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  the CPU consumes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be latched on that edge.
REQ-017 On acceptance the FSM SHALL go IDLE->WAIT with the wait counter loaded to WAIT_CYCLES-1, or IDLE->RESP when WAIT_CYCLES=0.
REQ-018 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 0.
REQ-019 The memory access (commit) SHALL happen on the edge that enters RESP; resp_valid SHALL rise 1+WAIT_CYCLES cycles after the acceptance edge.
REQ-020 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1, which SHALL return the FSM to IDLE.
REQ-021 A new request SHALL NOT be accepted on the same edge that retires a response; the minimum request spacing is 2+WAIT_CYCLES cycles.
REQ-022 An error SHALL be flagged when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS; for an error request, memory SHALL be left unchanged, resp_err SHALL be 1 and resp_rdata SHALL be 0.
REQ-023 A load with no error SHALL return mem[req_addr[31:2]] as it was before the commit edge.
REQ-024 A store with no error SHALL write req_wdata on the commit edge and return resp_rdata=0 and resp_err=0.
REQ-025 Outside RESP, resp_valid, resp_err and resp_rdata SHALL be 0.
REQ-026 req_valid held high while the FSM is in WAIT or RESP SHALL have no effect; the request SHALL be accepted at the next IDLE cycle.

Reset
REQ-027 Reset SHALL force state IDLE, wait counter 0, req_ready=1, resp_valid=0, resp_err=0 and resp_rdata=0 immediately, without waiting for a clock edge.
REQ-028 The storage array SHALL NOT be reset, so contents persist across reset.
REQ-029 Reset asserted during WAIT SHALL abort the request, and a store in flight SHALL NOT commit.
REQ-030 Reset asserted during RESP SHALL drop the pending response; a store that already committed SHALL remain written.

Structure
REQ-031 The package cpu_mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the default DEPTH_WORDS and WAIT_CYCLES values, and the wait-counter width (4).
REQ-032 The storage SHALL be the sub-module dmem_array: a single-port synchronous-write array with combinational read.
REQ-033 The FSM, the counter and the error check SHALL reside in data_mem_responder.

Verification
REQ-034 Reset, then a store to addr 0x10 with data 0xDEADBEEF and resp_ready=1 -> resp_valid high exactly 3 cycles after acceptance, resp_err=0, resp_rdata=0.
REQ-035 A load from 0x10 after that store -> resp_rdata=0xDEADBEEF and resp_err=0; with resp_ready held 0 for 4 cycles, the outputs stay stable and req_ready stays 0.
REQ-036 A load from 0x12 and a store to 0x400 (DEPTH_WORDS=256) -> resp_err=1 and resp_rdata=0; a later load from 0x400-4 returns its earlier value, unchanged.
REQ-037 With WAIT_CYCLES=0, back-to-back requests with req_valid held high -> acceptances every 2 cycles and resp_valid 1 cycle after each acceptance.
REQ-038 A store of 0x12345678 to 0x20, with rst_n pulsed low during WAIT -> outputs cleared asynchronously; a later load from 0x20 returns the old value, not 0x12345678.
REQ-039 rst_n pulsed low during RESP of a store of 0xCAFEF00D to 0x24 -> resp_valid drops at once; a later load from 0x24 returns 0xCAFEF00D.
